ysyx_25030093_ifu: RTL

- Multi-cycle instruction fetch unit. It sits directly upstream of the decode stage and replaces the combinational DPI instruction read.
- Accepts a next-PC from the PC stage, issues one read on a valid/ready memory bus, and presents the instruction plus its PC to decode over a valid/ready handshake.
- Single outstanding fetch; non-pipelined.

---
 rtl/ysyx_25030093_ifu_pkg.sv | 19 +
 rtl/ysyx_25030093_ifu.sv | 105 ++++++++++
 2 files changed

// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_25030093_ifu_pkg;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    AR,
    R,
    HOLD
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BUS      = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Multi-cycle instruction fetch unit: one outstanding read on a valid/ready bus,
// result held for decode until consumed.
module ysyx_25030093_ifu
  import ysyx_25030093_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             npc_valid,
  input  logic [31:0]      npc,
  output logic             npc_ready,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [1:0]       inst_err,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t      state;
  logic [31:0] pc_q;

  // Handshake outputs are pure decodes of the state register, so no input
  // reaches an output combinationally.
  assign npc_ready  = (state == IDLE);
  assign arvalid    = (state == AR);
  assign rready     = (state == R);
  assign inst_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc_q      <= '0;
      araddr    <= '0;
      inst      <= '0;
      inst_pc   <= '0;
      inst_err  <= ERR_NONE;
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == AR || state == R) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      case (state)
        BOOT: begin
          pc_q   <= RESET_PC;
          araddr <= RESET_PC;
          state  <= AR;
        end

        IDLE: begin
          if (npc_valid) begin
            pc_q <= npc;
            if (npc[1:0] == 2'b00) begin
              araddr <= npc;
              state  <= AR;
            end else begin
              // Misaligned PC never touches the bus; report it straight away.
              inst     <= '0;
              inst_pc  <= npc;
              inst_err <= ERR_MISALIGN;
              state    <= HOLD;
            end
          end
        end

        AR: begin
          if (arready) begin
            state <= R;
          end
        end

        R: begin
          if (rvalid) begin
            inst     <= rdata;
            inst_pc  <= pc_q;
            inst_err <= (rresp != RESP_OKAY) ? ERR_BUS : ERR_NONE;
            state    <= HOLD;
          end
        end

        HOLD: begin
          if (inst_ready) begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
            state     <= IDLE;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule
